// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with Hamming distance, valid/ready on both sides.
// S1 holds operands, S2 holds the registered result and its Zero/Ones flags.
module logic_unit_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Ones
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: a beat moves across an interface on a rising edge where valid
  // and ready are both high; flush beats every handshake on that edge.
  logic             r_v1;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_v2;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ones;

  logic             w_adv2;
  logic             w_adv1;
  logic             w_accept;
  logic [WIDTH-1:0] w_x;
  logic [CW-1:0]    w_pop;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_ones;

  assign w_adv2   = !r_v2 || out_ready;
  assign w_adv1   = r_v1 && w_adv2;
  assign in_ready = !r_v1 || w_adv2;
  assign w_accept = in_valid && in_ready;

  assign out_valid = r_v2;
  assign Result    = r_result;
  assign Zero      = r_zero;
  assign Ones      = r_ones;

  always_comb begin
    w_x   = r_a ^ r_b;
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + CW'(w_x[i]);
    end
    case (r_op)
      3'b000:  w_res = r_a & r_b;
      3'b001:  w_res = r_a | r_b;
      3'b010:  w_res = w_x;
      3'b011:  w_res = ~w_x;
      3'b100:  w_res = ~(r_a & r_b);
      3'b101:  w_res = ~(r_a | r_b);
      3'b110:  w_res = ~r_a;
      default: w_res = WIDTH'(w_pop);
    endcase
    // Flags come from the final result so HAM is judged on its count value.
    w_zero = (w_res == '0);
    w_ones = &w_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
    end else if (flush) begin
      r_v1 <= 1'b0;
    end else if (w_accept) begin
      r_v1 <= 1'b1;
    end else if (w_adv1) begin
      r_v1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op <= Op;
      r_a  <= A;
      r_b  <= B;
    end
  end

  // Result and flags are reset so the outputs read zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ones   <= 1'b0;
    end else if (flush) begin
      r_v2 <= 1'b0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_result <= w_res;
        r_zero   <= w_zero;
        r_ones   <= w_ones;
      end
    end
  end

endmodule
